// File: rtl/pwm_decoder.sv
// PWM input decoder: measures high time and period of pwm_in and divides them into a normalised duty.
// Optional stability filter on the synchronised input: define PWM_DEC_GLITCH_FILTER_EN.
module pwm_decoder #(
    parameter int CNT_W = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [OUT_W-1:0] duty,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int STEP_W = $clog2(OUT_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(OUT_W - 1);

    logic sync1_q, sync2_q, s_prev_q, s, rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= pwm_in;
            sync2_q  <= sync1_q;
            s_prev_q <= s;
        end
    end

`ifdef PWM_DEC_GLITCH_FILTER_EN
    // Level only moves once three consecutive synchronised samples agree.
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;
    always_comb begin
        hist_d = {hist_q[0], sync2_q};
        filt_d = (sync2_q == hist_q[0] && sync2_q == hist_q[1]) ? sync2_q : filt_q;
        s      = filt_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end
`else
    always_comb s = sync2_q;
`endif

    assign rise = s & ~s_prev_q;
    assign fall = ~s & s_prev_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, pcnt_q, pcnt_d, pcnt_inc;
    logic             publish, stuck_entry, busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        pcnt_d   = pcnt_q;
        publish  = 1'b0;
        pcnt_inc = pcnt_q + 1'b1;
        if (!en) begin
            state_d = IDLE;
            hcnt_d  = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE:  if (rise) begin state_d = HIGH; hcnt_d = CNT_W'(1); pcnt_d = CNT_W'(1); end
                       else pcnt_d = pcnt_inc;
                HIGH:  if (fall) begin state_d = LOW; pcnt_d = pcnt_inc; end
                       else begin hcnt_d = hcnt_q + 1'b1; pcnt_d = pcnt_inc; end
                LOW:   if (rise) begin
                           publish = 1'b1;
                           state_d = HIGH; hcnt_d = CNT_W'(1); pcnt_d = CNT_W'(1);
                       end else pcnt_d = pcnt_inc;
                STUCK: if (rise) begin state_d = HIGH; hcnt_d = CNT_W'(1); pcnt_d = CNT_W'(1); end
                       else if (fall) begin state_d = IDLE; hcnt_d = '0; pcnt_d = '0; end
                default: state_d = IDLE;
            endcase
            if (state_q != STUCK && pcnt_d == CNT_MAX) state_d = STUCK;
        end
    end

    always_comb begin
        stuck       = (state_q == STUCK);
        stuck_entry = (state_d == STUCK) && (state_q != STUCK);
        overrun     = publish && busy_q && !rst;
    end

    // Restoring divider: one quotient bit per cycle, OUT_W steps after load.
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W:0]    rem_q, rem_d, rem_sh, rem_nx;
    logic [CNT_W-1:0]  den_q, den_d, hh_q, hh_d, pp_q, pp_d;
    logic [OUT_W-1:0]  quo_q, quo_d, quo_nx;
    logic              busy_d, sat_q, sat_d, ge;
    logic [OUT_W-1:0]  duty_q, duty_d;
    logic [CNT_W-1:0]  high_q, high_d, period_q, period_d;
    logic              valid_q, valid_d;

    always_comb begin
        rem_sh   = {rem_q[CNT_W-1:0], 1'b0};
        ge       = rem_sh >= {1'b0, den_q};
        rem_nx   = ge ? rem_sh - {1'b0, den_q} : rem_sh;
        quo_nx   = {quo_q[OUT_W-2:0], ge};
        busy_d   = busy_q;
        step_d   = step_q;
        rem_d    = rem_q;
        den_d    = den_q;
        quo_d    = quo_q;
        sat_d    = sat_q;
        hh_d     = hh_q;
        pp_d     = pp_q;
        duty_d   = duty_q;
        high_d   = high_q;
        period_d = period_q;
        valid_d  = 1'b0;
        if (stuck_entry) begin
            busy_d   = 1'b0;
            duty_d   = s ? '1 : '0;
            high_d   = '0;
            period_d = '0;
            valid_d  = 1'b1;
        end else begin
            if (busy_q) begin
                rem_d  = rem_nx;
                quo_d  = quo_nx;
                step_d = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    busy_d   = 1'b0;
                    valid_d  = 1'b1;
                    duty_d   = sat_q ? '1 : quo_nx;
                    high_d   = hh_q;
                    period_d = pp_q;
                end
            end
            if (publish && !busy_q) begin
                busy_d = 1'b1;
                step_d = '0;
                rem_d  = {1'b0, hcnt_q};
                den_d  = pcnt_q;
                quo_d  = '0;
                sat_d  = hcnt_q >= pcnt_q;
                hh_d   = hcnt_q;
                pp_d   = pcnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            step_q   <= '0;
            rem_q    <= '0;
            den_q    <= '0;
            quo_q    <= '0;
            sat_q    <= 1'b0;
            hh_q     <= '0;
            pp_q     <= '0;
            duty_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            step_q   <= step_d;
            rem_q    <= rem_d;
            den_q    <= den_d;
            quo_q    <= quo_d;
            sat_q    <= sat_d;
            hh_q     <= hh_d;
            pp_q     <= pp_d;
            duty_q   <= duty_d;
            high_q   <= high_d;
            period_q <= period_d;
            valid_q  <= valid_d;
        end
    end

    assign duty       = duty_q;
    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign valid      = valid_q;
endmodule
